// File: rtl/moving_avg_mc_filter_if.sv
// Sample stream bundle for the multi-channel moving-average filter.
// The slave side is the filter; the master side is the sample source plus
// the downstream consumer (which owns out_ready).
interface moving_avg_mc_filter_if #(
    parameter int WIDTH = 16,
    parameter int CHW   = 2
);
    logic             in_valid;
    logic             in_ready;
    logic [CHW-1:0]   in_ch;
    logic [WIDTH-1:0] in_sample;
    logic             out_valid;
    logic             out_ready;
    logic [CHW-1:0]   out_ch;
    logic [WIDTH-1:0] out_sample;

    modport slave (
        input  in_valid, in_ch, in_sample, out_ready,
        output in_ready, out_valid, out_ch, out_sample
    );

    modport master (
        output in_valid, in_ch, in_sample, out_ready,
        input  in_ready, out_valid, out_ch, out_sample
    );
endinterface

// File: rtl/moving_avg_mc_filter.sv
// Multi-channel, runtime-configurable moving-average filter.
// CH channels share one datapath; each keeps its own circular buffer, write
// pointer, fill count and running sum. Window N = 2^shift_q is reloaded by
// cfg_load_i, which also clears every channel's fill/ptr/sum. Old-sample
// read is asynchronous, so a channel can be fed every cycle with no bubble.
module moving_avg_mc_filter #(
    parameter int WIDTH     = 16,
    parameter int CH        = 4,
    parameter int MAX_SHIFT = 5,
    parameter int DO_ROUND  = 1
) (
    input  logic                           clk,
    input  logic                           rst_n,
    input  logic [$clog2(MAX_SHIFT+1)-1:0] cfg_shift_i,
    input  logic                           cfg_load_i,
    moving_avg_mc_filter_if.slave          bus,
    output logic                           err_ch_o
);

    localparam int CHW   = (CH > 1) ? $clog2(CH) : 1;
    localparam int SW    = $clog2(MAX_SHIFT + 1);
    localparam int DEPTH = 1 << MAX_SHIFT;
    localparam int SUMW  = WIDTH + MAX_SHIFT;
    localparam int FILLW = MAX_SHIFT + 1;

    localparam logic [SW-1:0] MAX_S = SW'(MAX_SHIFT);

    // Per-channel state
    logic [WIDTH-1:0]        mem_q  [CH][DEPTH];
    logic [MAX_SHIFT-1:0]    ptr_q  [CH];
    logic [FILLW-1:0]        fill_q [CH];
    logic signed [SUMW-1:0]  sum_q  [CH];

    // Shared configuration and output register
    logic [SW-1:0]           shift_q;
    logic                    out_valid_q;
    logic [CHW-1:0]          out_ch_q;
    logic [WIDTH-1:0]        out_sample_q;
    logic                    err_q;

    // Datapath
    logic                    in_ready;
    logic                    accept;
    logic                    ch_ok;
    logic [CHW-1:0]          ch_idx;
    logic [FILLW-1:0]        win_n;
    logic [MAX_SHIFT-1:0]    win_last;
    logic [MAX_SHIFT-1:0]    cur_ptr;
    logic [FILLW-1:0]        cur_fill;
    logic                    full;
    logic [WIDTH-1:0]        old_sample;
    logic signed [SUMW-1:0]  in_ext;
    logic signed [SUMW-1:0]  old_ext;
    logic signed [SUMW-1:0]  sum_d;
    logic [FILLW-1:0]        fill_d;
    logic [MAX_SHIFT-1:0]    ptr_d;
    logic                    beat;
    logic signed [SUMW:0]    rnd;
    logic signed [SUMW:0]    rounded;
    logic [WIDTH-1:0]        sample_d;
    logic [SW-1:0]           shift_d;

    // When CH fills the channel field exactly, no out-of-range code exists.
    generate
        if (CH == (1 << CHW)) begin : g_ch_full
            assign ch_ok = 1'b1;
        end else begin : g_ch_part
            localparam logic [CHW:0] CH_LIM = (CHW + 1)'(CH);
            assign ch_ok = ({1'b0, bus.in_ch} < CH_LIM);
        end
    endgenerate

    // A pending beat blocks input unless it leaves this cycle; cfg_load always refuses.
    assign in_ready = !cfg_load_i && (!out_valid_q || bus.out_ready);
    assign accept   = bus.in_valid && in_ready;

    // Per-accept update of the addressed channel and the averaged result.
    always_comb begin
        ch_idx     = ch_ok ? bus.in_ch : '0;
        win_n      = FILLW'(1) << shift_q;
        win_last   = MAX_SHIFT'(win_n - 1'b1);
        cur_ptr    = ptr_q[ch_idx];
        cur_fill   = fill_q[ch_idx];
        full       = (cur_fill == win_n);
        old_sample = full ? mem_q[ch_idx][cur_ptr] : '0;
        in_ext     = {{MAX_SHIFT{bus.in_sample[WIDTH-1]}}, bus.in_sample};
        old_ext    = {{MAX_SHIFT{old_sample[WIDTH-1]}}, old_sample};
        sum_d      = sum_q[ch_idx] + in_ext - old_ext;
        fill_d     = full ? cur_fill : cur_fill + 1'b1;
        ptr_d      = (cur_ptr == win_last) ? '0 : cur_ptr + 1'b1;
        beat       = (fill_d == win_n);
        rnd        = '0;
        if (DO_ROUND != 0 && shift_q != '0) begin
            rnd = (SUMW + 1)'(1) << (shift_q - 1'b1);
        end
        rounded    = {sum_d[SUMW-1], sum_d} + rnd;
        // A full window of in-range samples keeps the quotient inside WIDTH.
        sample_d   = WIDTH'(rounded >>> shift_q);
        shift_d    = (cfg_shift_i > MAX_S) ? MAX_S : cfg_shift_i;
    end

    // Channel bookkeeping: cfg_load wins over any accept (which it blocks anyway).
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            shift_q <= MAX_S;
            for (int c = 0; c < CH; c++) begin
                ptr_q[c]  <= '0;
                fill_q[c] <= '0;
                sum_q[c]  <= '0;
            end
        end else if (cfg_load_i) begin
            shift_q <= shift_d;
            for (int c = 0; c < CH; c++) begin
                ptr_q[c]  <= '0;
                fill_q[c] <= '0;
                sum_q[c]  <= '0;
            end
        end else if (accept && ch_ok) begin
            ptr_q[ch_idx]  <= ptr_d;
            fill_q[ch_idx] <= fill_d;
            sum_q[ch_idx]  <= sum_d;
        end
    end

    // Sample buffers are never cleared; fill gating hides stale contents.
    always_ff @(posedge clk) begin
        if (accept && ch_ok) begin
            mem_q[ch_idx][cur_ptr] <= bus.in_sample;
        end
    end

    // Output beat register: reload on a beat-producing accept, hold under backpressure.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid_q  <= 1'b0;
            out_ch_q     <= '0;
            out_sample_q <= '0;
        end else if (cfg_load_i) begin
            out_valid_q  <= 1'b0;
        end else if (accept) begin
            out_valid_q <= ch_ok && beat;
            if (ch_ok && beat) begin
                out_ch_q     <= bus.in_ch;
                out_sample_q <= sample_d;
            end
        end else if (bus.out_ready) begin
            out_valid_q  <= 1'b0;
        end
    end

    // Sticky flag for samples addressed to a non-existent channel.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            err_q <= 1'b0;
        end else if (accept && !ch_ok) begin
            err_q <= 1'b1;
        end
    end

    assign bus.in_ready   = in_ready;
    assign bus.out_valid  = out_valid_q;
    assign bus.out_ch     = out_ch_q;
    assign bus.out_sample = out_sample_q;
    assign err_ch_o       = err_q;

endmodule

// File: tb/tb_moving_avg_mc_filter.sv
// Directed bench for moving_avg_mc_filter. Two instances: A (CH=4, rounding)
// and B (CH=3, truncating, so an out-of-range channel code exists).
// Expected beats come from a window-sum model and are queued per instance.
module tb_moving_avg_mc_filter;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst_n;
    logic [2:0] cfg_shift_a, cfg_shift_b;
    logic       cfg_load_a, cfg_load_b;
    logic       err_a, err_b;

    moving_avg_mc_filter_if #(.WIDTH(16), .CHW(2)) a_if ();
    moving_avg_mc_filter_if #(.WIDTH(16), .CHW(2)) b_if ();

    moving_avg_mc_filter #(.WIDTH(16), .CH(4), .MAX_SHIFT(5), .DO_ROUND(1)) dut_a (
        .clk(clk), .rst_n(rst_n), .cfg_shift_i(cfg_shift_a), .cfg_load_i(cfg_load_a),
        .bus(a_if.slave), .err_ch_o(err_a));

    moving_avg_mc_filter #(.WIDTH(16), .CH(3), .MAX_SHIFT(5), .DO_ROUND(0)) dut_b (
        .clk(clk), .rst_n(rst_n), .cfg_shift_i(cfg_shift_b), .cfg_load_i(cfg_load_b),
        .bus(b_if.slave), .err_ch_o(err_b));

    typedef struct {
        int ch;
        int smp;
    } beat_t;

    int    checks = 0;
    int    errors = 0;
    beat_t exp_a[$];
    beat_t exp_b[$];

    int m_shift [2];
    int m_cnt   [2][4];
    int m_hist  [2][4][32];
    int ch_num  [2] = '{4, 3};
    int do_rnd  [2] = '{1, 0};

    task automatic chk(string tag, logic signed [63:0] obs, logic signed [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    function automatic logic rdy(int d);
        return (d == 0) ? a_if.in_ready : b_if.in_ready;
    endfunction

    function automatic logic ovalid(int d);
        return (d == 0) ? a_if.out_valid : b_if.out_valid;
    endfunction

    function automatic logic ordy(int d);
        return (d == 0) ? a_if.out_ready : b_if.out_ready;
    endfunction

    function automatic int qsize(int d);
        return (d == 0) ? exp_a.size() : exp_b.size();
    endfunction

    task automatic drive(int d, logic v, int ch, int s);
        logic [1:0]  c2;
        logic [15:0] s16;
        c2  = ch[1:0];
        s16 = s[15:0];
        if (d == 0) begin
            a_if.in_valid = v; a_if.in_ch = c2; a_if.in_sample = s16;
        end else begin
            b_if.in_valid = v; b_if.in_ch = c2; b_if.in_sample = s16;
        end
    endtask

    task automatic model_clear(int d);
        for (int c = 0; c < 4; c++) m_cnt[d][c] = 0;
    endtask

    // Explicit sum over the last N accepted samples of the channel.
    task automatic model_accept(int d, int ch, int s);
        int     n;
        longint sum;
        longint rnd;
        beat_t  b;
        if (ch >= ch_num[d]) return;
        m_hist[d][ch][m_cnt[d][ch] % 32] = s;
        m_cnt[d][ch]++;
        n = 1 << m_shift[d];
        if (m_cnt[d][ch] >= n) begin
            sum = 0;
            for (int i = 0; i < n; i++) sum += m_hist[d][ch][(m_cnt[d][ch] - 1 - i) % 32];
            rnd = (do_rnd[d] != 0 && m_shift[d] > 0) ? (longint'(1) << (m_shift[d] - 1)) : 0;
            b.ch  = ch;
            b.smp = int'((sum + rnd) >>> m_shift[d]);
            if (d == 0) exp_a.push_back(b); else exp_b.push_back(b);
        end
    endtask

    task automatic send(int d, int ch, int s);
        bit ok;
        ok = 1'b0;
        drive(d, 1'b1, ch, s);
        for (int k = 0; k < 50; k++) begin
            @(negedge clk);
            if (rdy(d)) begin ok = 1'b1; break; end
        end
        chk("send_accepted", ok, 1);
        if (ok) model_accept(d, ch, s);
        @(posedge clk); #1;
        drive(d, 1'b0, 0, 0);
    endtask

    task automatic cfg(int d, int sh, bit with_sample);
        if (d == 0) begin cfg_shift_a = sh[2:0]; cfg_load_a = 1'b1; end
        else        begin cfg_shift_b = sh[2:0]; cfg_load_b = 1'b1; end
        if (with_sample) drive(d, 1'b1, 0, 99);
        @(negedge clk);
        chk("cfg_in_ready_low", rdy(d), 0);
        if (!ordy(d)) begin
            if (d == 0) exp_a.delete(); else exp_b.delete();
        end
        model_clear(d);
        m_shift[d] = (sh > 5) ? 5 : sh;
        @(posedge clk); #1;
        cfg_load_a = 1'b0;
        cfg_load_b = 1'b0;
        drive(d, 1'b0, 0, 0);
        chk("cfg_out_valid_cleared", ovalid(d), 0);
    endtask

    task automatic drain(int d);
        for (int k = 0; k < 40; k++) begin
            if (qsize(d) == 0 && !ovalid(d)) break;
            @(posedge clk); #1;
        end
        chk("drain_queue_empty", qsize(d), 0);
        chk("drain_out_valid", ovalid(d), 0);
    endtask

    // Scoreboard pop for instance A: a beat transfers at the next rising edge.
    always @(negedge clk) begin
        beat_t e;
        if (rst_n && a_if.out_valid && a_if.out_ready) begin
            chk("a_beat_expected", exp_a.size() > 0, 1);
            if (exp_a.size() > 0) begin
                e = exp_a.pop_front();
                chk("a_out_ch", a_if.out_ch, e.ch);
                chk("a_out_sample", $signed(a_if.out_sample), e.smp);
            end
        end
    end

    // Scoreboard pop for instance B.
    always @(negedge clk) begin
        beat_t e;
        if (rst_n && b_if.out_valid && b_if.out_ready) begin
            chk("b_beat_expected", exp_b.size() > 0, 1);
            if (exp_b.size() > 0) begin
                e = exp_b.pop_front();
                chk("b_out_ch", b_if.out_ch, e.ch);
                chk("b_out_sample", $signed(b_if.out_sample), e.smp);
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        beat_t held;
        int    v;

        rst_n = 1'b0;
        cfg_shift_a = '0; cfg_shift_b = '0;
        cfg_load_a = 1'b0; cfg_load_b = 1'b0;
        drive(0, 1'b0, 0, 0);
        drive(1, 1'b0, 0, 0);
        a_if.out_ready = 1'b1;
        b_if.out_ready = 1'b1;
        m_shift[0] = 5; m_shift[1] = 5;
        model_clear(0); model_clear(1);

        repeat (3) @(posedge clk);
        #1;
        chk("rst_out_valid", a_if.out_valid, 0);
        chk("rst_out_ch", a_if.out_ch, 0);
        chk("rst_out_sample", a_if.out_sample, 0);
        chk("rst_err_a", err_a, 0);
        chk("rst_err_b", err_b, 0);
        chk("rst_in_ready", a_if.in_ready, 1);
        rst_n = 1'b1;
        @(posedge clk); #1;

        // Ramp on ch0, N=4: beats 3 then 4
        cfg(0, 2, 0);
        for (int i = 1; i <= 5; i++) begin
            send(0, 0, i);
            if (i == 3) chk("ramp_warmup_no_beat", a_if.out_valid, 0);
        end
        drain(0);

        // Interleaved channels must not mix
        cfg(0, 2, 0);
        for (int i = 0; i < 6; i++) begin
            send(0, 0, 8);
            send(0, 1, -4);
        end
        drain(0);

        // Rounding vs truncation, then full-scale extremes
        cfg(0, 1, 0);
        send(0, 2, -1);
        send(0, 2, -2);
        cfg(1, 1, 0);
        send(1, 2, -1);
        send(1, 2, -2);
        send(0, 3, 32767);
        send(0, 3, 32767);
        send(0, 1, -32768);
        send(0, 1, -32768);
        drain(0);
        drain(1);

        // Backpressure: hold a beat for 5 cycles, then resume streaming
        cfg(0, 3, 0);
        for (int i = 0; i < 7; i++) begin
            v = int'($urandom_range(2000)) - 1000;
            send(0, 0, v);
        end
        a_if.out_ready = 1'b0;
        v = int'($urandom_range(2000)) - 1000;
        send(0, 0, v);
        held = exp_a[0];
        drive(0, 1'b1, 1, 1234);
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            chk("bp_out_valid_held", a_if.out_valid, 1);
            chk("bp_in_ready_low", a_if.in_ready, 0);
            chk("bp_out_ch_held", a_if.out_ch, held.ch);
            chk("bp_out_sample_held", $signed(a_if.out_sample), held.smp);
        end
        @(posedge clk); #1;
        drive(0, 1'b0, 0, 0);
        a_if.out_ready = 1'b1;
        for (int i = 0; i < 6; i++) begin
            v = int'($urandom_range(2000)) - 1000;
            send(0, 0, v);
        end
        drain(0);

        // Reconfigure with a pending beat: beat dropped, sample refused, then 1:1
        a_if.out_ready = 1'b0;
        send(0, 0, 77);
        chk("reconf_pending", a_if.out_valid, 1);
        cfg(0, 0, 1);
        a_if.out_ready = 1'b1;
        send(0, 0, 5);
        send(0, 1, -7);
        send(0, 0, 300);
        drain(0);

        // Out-of-range shift clamps to 5: 31 silent samples, then beats
        cfg(0, 7, 0);
        for (int i = 0; i < 31; i++) begin
            v = int'($urandom_range(60000)) - 30000;
            send(0, 2, v);
        end
        chk("clamp_warmup_no_beat", a_if.out_valid, 0);
        for (int i = 0; i < 2; i++) begin
            v = int'($urandom_range(60000)) - 30000;
            send(0, 2, v);
        end
        drain(0);

        // Bad channel on the 3-channel instance
        send(1, 0, 10);
        send(1, 3, 500);
        chk("bad_ch_err_set", err_b, 1);
        chk("bad_ch_no_beat", b_if.out_valid, 0);
        send(1, 0, 20);
        send(1, 1, 3);
        send(1, 1, 4);
        chk("bad_ch_err_sticky", err_b, 1);
        chk("bad_ch_err_a_clear", err_a, 0);
        drain(1);

        // Reset mid-stream with a beat pending
        a_if.out_ready = 1'b0;
        cfg(0, 1, 0);
        send(0, 0, 4);
        send(0, 0, 6);
        chk("pre_reset_pending", a_if.out_valid, 1);
        #2;
        rst_n = 1'b0;
        #1;
        chk("midrst_out_valid_a", a_if.out_valid, 0);
        chk("midrst_err_b", err_b, 0);
        exp_a.delete();
        exp_b.delete();
        m_shift[0] = 5; m_shift[1] = 5;
        model_clear(0); model_clear(1);
        @(posedge clk); #1;
        rst_n = 1'b1;
        a_if.out_ready = 1'b1;
        for (int i = 0; i < 3; i++) send(0, 0, 100);
        chk("post_rst_warmup", a_if.out_valid, 0);
        drain(0);
        drain(1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
